fe12_mul_pack_s: RTL

Upstream operand packer for the streaming Fp12 multiplier (`ec_fe12_mul_s`). The block takes two independent 12-beat Fp12 operand packets, one beat per Fp coefficient: operand a on one stream and operand b on another. It emits the single 12-beat `{b, a}` interleaved stream that `i_mul_fe12_if` of the multiplier consumes. Operand a is buffered in full. Operand b is then paired beat-by-beat through a one-register output stage.

---
 rtl/fe12_mul_pack_s.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fe12_mul_pack_s.sv
// -----------------------------------------------------------------------------
// fe12_mul_pack_s
//
// Operand packer in front of the streaming Fp12 multiplier. It collects one
// 12-beat Fp12 operand a (one Fp coefficient per beat) into a local buffer,
// then pairs each beat of operand b with the matching buffered a coefficient.
// The result is a single {b, a} stream delivered through a one-register
// output stage. The datapath only routes coefficients; it performs no
// arithmetic and no reduction.
//
// Ports
//   i_clk, i_rst      : clock (rising edge), asynchronous active-low reset
//   a_*_i / a_rdy_o   : operand a stream sink (dat, val, sop, eop, ctl)
//   b_*_i / b_rdy_o   : operand b stream sink (dat, val, eop, err)
//   mul_*_o/mul_rdy_i : paired stream source; dat = {b, a}, mod is always 0
// -----------------------------------------------------------------------------
module fe12_mul_pack_s #(
    parameter int FE_BITS  = 384,
    parameter int CTL_BITS = 32,
    parameter int NUM_ELEM = 12,
    parameter int MOD_BITS = $clog2(2 * FE_BITS / 8)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    // operand a stream
    input  logic [FE_BITS-1:0]   a_dat_i,
    input  logic                 a_val_i,
    input  logic                 a_sop_i,
    input  logic                 a_eop_i,
    input  logic [CTL_BITS-1:0]  a_ctl_i,
    output logic                 a_rdy_o,
    // operand b stream
    input  logic [FE_BITS-1:0]   b_dat_i,
    input  logic                 b_val_i,
    input  logic                 b_eop_i,
    input  logic                 b_err_i,
    output logic                 b_rdy_o,
    // paired output stream
    output logic [2*FE_BITS-1:0] mul_dat_o,
    output logic                 mul_val_o,
    output logic                 mul_sop_o,
    output logic                 mul_eop_o,
    output logic                 mul_err_o,
    output logic [CTL_BITS-1:0]  mul_ctl_o,
    output logic [MOD_BITS-1:0]  mul_mod_o,
    input  logic                 mul_rdy_i
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ELEM - 1);
    localparam logic [3:0] NUM_IDX  = 4'(NUM_ELEM);

    typedef enum logic {
        LOAD_A,
        PAIR
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            a_cnt_q, a_cnt_d;
    logic [3:0]            p_cnt_q, p_cnt_d;
    logic [CTL_BITS-1:0]   ctl_q, ctl_d;
    logic                  len_err_q, len_err_d;
    // One bit per buffer entry: set when the entry was written by the
    // current a packet, so stale coefficients from older packets read as 0.
    logic [NUM_ELEM-1:0]   wr_mask_q, wr_mask_d;
    // Holds ready low until the first clock edge after reset release.
    logic                  run_q;

    logic [2*FE_BITS-1:0]  out_dat_q, out_dat_d;
    logic                  out_val_q, out_val_d;
    logic                  out_sop_q, out_sop_d;
    logic                  out_eop_q, out_eop_d;
    logic                  out_err_q, out_err_d;
    logic [CTL_BITS-1:0]   out_ctl_q, out_ctl_d;

    logic [FE_BITS-1:0]    a_buf [NUM_ELEM];
    logic                  a_wr_en;
    logic [3:0]            a_wr_idx;
    logic [FE_BITS-1:0]    a_sel;
    logic                  a_fire;
    logic                  b_fire;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        a_cnt_d   = a_cnt_q;
        p_cnt_d   = p_cnt_q;
        ctl_d     = ctl_q;
        len_err_d = len_err_q;
        wr_mask_d = wr_mask_q;
        out_dat_d = out_dat_q;
        out_val_d = out_val_q;
        out_sop_d = out_sop_q;
        out_eop_d = out_eop_q;
        out_err_d = out_err_q;
        out_ctl_d = out_ctl_q;
        a_wr_en   = 1'b0;
        // A sop beat always lands in entry 0, restarting the packet.
        a_wr_idx  = a_sop_i ? 4'd0 : a_cnt_q;
        a_sel     = '0;

        a_rdy_o = run_q && (state_q == LOAD_A);
        b_rdy_o = run_q && (state_q == PAIR) && (!out_val_q || mul_rdy_i);
        a_fire  = a_val_i && a_rdy_o;
        b_fire  = b_val_i && b_rdy_o;

        if (p_cnt_q < NUM_IDX) begin
            if (wr_mask_q[p_cnt_q]) begin
                a_sel = a_buf[p_cnt_q];
            end
        end

        // Output register empties on a handshake unless refilled below.
        if (mul_rdy_i) begin
            out_val_d = 1'b0;
        end

        case (state_q)
            LOAD_A: begin
                if (a_fire) begin
                    a_wr_en = 1'b1;
                    a_cnt_d = a_wr_idx + 4'd1;
                    if (a_sop_i) begin
                        ctl_d     = a_ctl_i;
                        wr_mask_d = '0;
                    end
                    wr_mask_d[a_wr_idx] = 1'b1;
                    // Early eop and missing eop on the last slot are both
                    // length errors.
                    if (a_eop_i != (a_wr_idx == LAST_IDX)) begin
                        len_err_d = 1'b1;
                    end
                    if (a_eop_i || (a_wr_idx == LAST_IDX)) begin
                        state_d = PAIR;
                        p_cnt_d = 4'd0;
                    end
                end
            end
            PAIR: begin
                if (b_fire) begin
                    out_val_d = 1'b1;
                    out_dat_d = {b_dat_i, a_sel};
                    out_sop_d = (p_cnt_q == 4'd0);
                    out_eop_d = b_eop_i;
                    out_err_d = len_err_q || b_err_i ||
                                (b_eop_i && (p_cnt_q != LAST_IDX)) ||
                                (p_cnt_q >= NUM_IDX);
                    out_ctl_d = ctl_q;
                    p_cnt_d   = (p_cnt_q == 4'hF) ? p_cnt_q : p_cnt_q + 4'd1;
                    if (b_eop_i) begin
                        len_err_d = 1'b0;
                        a_cnt_d   = 4'd0;
                        wr_mask_d = '0;
                        state_d   = LOAD_A;
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= LOAD_A;
            a_cnt_q   <= '0;
            p_cnt_q   <= '0;
            ctl_q     <= '0;
            len_err_q <= 1'b0;
            wr_mask_q <= '0;
            run_q     <= 1'b0;
            out_dat_q <= '0;
            out_val_q <= 1'b0;
            out_sop_q <= 1'b0;
            out_eop_q <= 1'b0;
            out_err_q <= 1'b0;
            out_ctl_q <= '0;
        end else begin
            state_q   <= state_d;
            a_cnt_q   <= a_cnt_d;
            p_cnt_q   <= p_cnt_d;
            ctl_q     <= ctl_d;
            len_err_q <= len_err_d;
            wr_mask_q <= wr_mask_d;
            run_q     <= 1'b1;
            out_dat_q <= out_dat_d;
            out_val_q <= out_val_d;
            out_sop_q <= out_sop_d;
            out_eop_q <= out_eop_d;
            out_err_q <= out_err_d;
            out_ctl_q <= out_ctl_d;
        end
    end

    // NOTE: the coefficient buffer has no reset; wr_mask_q already marks
    // which entries are meaningful, and leaving storage unreset keeps it a
    // plain RAM-style array.
    always_ff @(posedge i_clk) begin
        if (a_wr_en) begin
            a_buf[a_wr_idx] <= a_dat_i;
        end
    end

    assign mul_dat_o = out_dat_q;
    assign mul_val_o = out_val_q;
    assign mul_sop_o = out_sop_q;
    assign mul_eop_o = out_eop_q;
    assign mul_err_o = out_err_q;
    assign mul_ctl_o = out_ctl_q;
    assign mul_mod_o = '0;

endmodule
